// File: rtl/uart_tx_feeder.sv
// Circular byte FIFO feeding a UART transmitter with one-cycle load strobes.
// Optional flush logic enabled by defining UART_TX_FEEDER_FLUSH_EN.
module uart_tx_feeder #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  txclk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  flush,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  ld_tx_data,
   output logic [7:0]            tx_data,
   input  logic                  tx_empty
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SETTLE
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [DEPTH_LOG2:0]   count_nxt;
   logic                  flush_act;
   logic                  wr_ok;
   logic                  wr_rej;
   logic                  pop;

`ifdef UART_TX_FEEDER_FLUSH_EN
   assign flush_act = flush;
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign flush_act    = 1'b0;
`endif

   // full is a registered image of count == depth
   assign wr_ok  = wr_en & ~full & ~flush_act;
   assign wr_rej = wr_en &  full & ~flush_act;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_empty && (count != '0) && !flush_act) begin
               state_nxt = LOAD;
               pop       = 1'b1;
            end
         end
         LOAD:    state_nxt = SETTLE;
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      count_nxt = count;
      case ({wr_ok, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
      if (flush_act) begin
         count_nxt = '0;
      end
   end

   always_ff @(posedge txclk) begin
      if (reset) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         full       <= 1'b0;
         overflow   <= 1'b0;
         ld_tx_data <= 1'b0;
         tx_data    <= 8'h00;
      end else begin
         state      <= state_nxt;
         ld_tx_data <= pop;
         count      <= count_nxt;
         full       <= (count_nxt == DEPTH_CNT);
         if (pop) begin
            tx_data <= mem[rptr];
         end
         if (flush_act) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
         end else begin
            if (wr_ok) begin
               wptr <= wptr + 1'b1;
            end
            if (pop) begin
               rptr <= rptr + 1'b1;
            end
            if (wr_rej) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // storage carries no reset; stale contents are unreachable via the pointers
   always_ff @(posedge txclk) begin
      if (wr_ok) begin
         mem[wptr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: load timing, full/overflow, ordering,
// pointer wrap, flush and mid-strobe reset.
module tb_uart_tx_feeder;

   logic       txclk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       flush;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       ld_tx_data;
   logic [7:0] tx_data;
   logic       tx_empty;

   int errors = 0;
   int checks = 0;

   always #5 txclk = ~txclk;

   uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
      .txclk      (txclk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .flush      (flush),
      .full       (full),
      .count      (count),
      .overflow   (overflow),
      .ld_tx_data (ld_tx_data),
      .tx_data    (tx_data),
      .tx_empty   (tx_empty)
   );

   task automatic tick;
      @(posedge txclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART model: raise tx_empty, wait (bounded) for one strobe, drop tx_empty
   task automatic expect_byte(input logic [7:0] b, input string tag);
      bit got;
      got = 1'b0;
      tx_empty = 1'b1;
      for (int c = 0; c < 8 && !got; c++) begin
         tick;
         got = ld_tx_data;
      end
      chk({tag, "_strobe"}, 32'(got), 1);
      chk({tag, "_data"}, 32'(tx_data), 32'(b));
      tx_empty = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         chk({tag, "_quiet"}, 32'(ld_tx_data), 0);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      tick;
      wr_en   = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      flush    = 1'b0;
      tx_empty = 1'b0;
      tick;
      tick;
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_ld", 32'(ld_tx_data), 0);
      chk("rst_data", 32'(tx_data), 0);
      reset = 1'b0;

      // earliest strobe
      tx_empty = 1'b1;
      write_byte(8'hA5);
      chk("t1_count_e0", 32'(count), 1);
      chk("t1_ld_e0", 32'(ld_tx_data), 0);
      tick;
      chk("t1_ld_e1", 32'(ld_tx_data), 1);
      chk("t1_data_e1", 32'(tx_data), 'hA5);
      chk("t1_count_e1", 32'(count), 0);
      tx_empty = 1'b0;
      tick;
      chk("t1_ld_e2", 32'(ld_tx_data), 0);
      chk("t1_hold", 32'(tx_data), 'hA5);
      tick;

      // fill and overflow
      for (int i = 0; i < 16; i++) begin
         write_byte(8'(i));
         chk("t2_noload", 32'(ld_tx_data), 0);
      end
      chk("t2_full", 32'(full), 1);
      chk("t2_count16", 32'(count), 16);
      chk("t2_ovf0", 32'(overflow), 0);
      write_byte(8'hFF);
      chk("t2_ovf1", 32'(overflow), 1);
      chk("t2_count_keep", 32'(count), 16);
      chk("t2_full_keep", 32'(full), 1);

      // drain in order
      for (int k = 0; k < 16; k++) begin
         expect_byte(8'(k), $sformatf("t3_b%0d", k));
      end
      chk("t3_count0", 32'(count), 0);
      chk("t3_full0", 32'(full), 0);
      chk("t3_ovf_sticky", 32'(overflow), 1);

      // pointers now at 1; build count 5 near the wrap point
      for (int i = 0; i < 13; i++) begin
         write_byte(8'h30 + 8'(i));
      end
      for (int i = 0; i < 8; i++) begin
         expect_byte(8'h30 + 8'(i), $sformatf("t4_pre%0d", i));
      end
      chk("t4_count5", 32'(count), 5);
      for (int i = 0; i < 4; i++) begin
         tx_empty = 1'b1;
         write_byte(8'h40 + 8'(i));
         tx_empty = 1'b0;
         chk("t4_ld", 32'(ld_tx_data), 1);
         chk("t4_data", 32'(tx_data), 32'(8'h38 + 8'(i)));
         chk("t4_count_same", 32'(count), 5);
         tick;
         tick;
      end
      expect_byte(8'h3C, "t4_wrap0");
      for (int i = 0; i < 4; i++) begin
         expect_byte(8'h40 + 8'(i), $sformatf("t4_wrap%0d", i + 1));
      end
      chk("t4_count0", 32'(count), 0);

      // flush with count 7
      for (int i = 0; i < 7; i++) begin
         write_byte(8'h50 + 8'(i));
      end
      chk("t5_count7", 32'(count), 7);
      flush = 1'b1;
`ifdef UART_TX_FEEDER_FLUSH_EN
      wr_en   = 1'b1;
      wr_data = 8'h99;
`endif
      tick;
      flush = 1'b0;
      wr_en = 1'b0;
`ifdef UART_TX_FEEDER_FLUSH_EN
      chk("t5_count0", 32'(count), 0);
      chk("t5_ovf0", 32'(overflow), 0);
      chk("t5_full0", 32'(full), 0);
      tx_empty = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick;
         chk("t5_nostrobe", 32'(ld_tx_data), 0);
      end
      tx_empty = 1'b0;
`else
      chk("t5_count7_kept", 32'(count), 7);
      chk("t5_ovf_kept", 32'(overflow), 1);
`endif

      // reset during LOAD
      write_byte(8'h77);
      tx_empty = 1'b1;
      tick;
      chk("t6_in_load", 32'(ld_tx_data), 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("t6_ld0", 32'(ld_tx_data), 0);
      chk("t6_data0", 32'(tx_data), 0);
      chk("t6_count0", 32'(count), 0);
      chk("t6_full0", 32'(full), 0);
      chk("t6_ovf0", 32'(overflow), 0);
      write_byte(8'hC3);
      chk("t6_ld_e0", 32'(ld_tx_data), 0);
      chk("t6_count1", 32'(count), 1);
      tick;
      chk("t6_ld_e1", 32'(ld_tx_data), 1);
      chk("t6_data_e1", 32'(tx_data), 'hC3);
      tx_empty = 1'b0;
      tick;
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
